// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    S_NORM  = 1'b0,
    S_BURST = 1'b1
  } arb_state_t;

  localparam logic [15:0] DEAD      = 16'hDEAD;
  localparam int          RANGE_BIT = 13;

endpackage

// File: rtl/arb_wait_ctr.sv
// Saturating DMA wait counter; o_at_limit flags that DMA has waited MAXWAIT cycles.
module arb_wait_ctr #(
  parameter int MAXWAIT = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_limit
);

  localparam int CW = (MAXWAIT < 1) ? 1 : $clog2(MAXWAIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CW'(MAXWAIT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == CW'(MAXWAIT));

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter for a single-port synchronous data memory with DMA burst lock.
// Define DMEM_ARB_STARVE_EN to add the forced DMA grant after MAXWAIT denied cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DBITS   = 16,
  parameter int ABITS   = 12,
  parameter int MAXWAIT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [DBITS-1:0] cpu_addr,
  input  logic [DBITS-1:0] cpu_din,
  output logic             cpu_gnt,
  output logic             cpu_rvalid,
  output logic [DBITS-1:0] cpu_dout,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic             dma_lock,
  input  logic [DBITS-1:0] dma_addr,
  input  logic [DBITS-1:0] dma_din,
  output logic             dma_gnt,
  output logic             dma_rvalid,
  output logic [DBITS-1:0] dma_dout,
  output logic [ABITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_din,
  output logic             mem_we,
  input  logic [DBITS-1:0] mem_dout
);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic             w_force;
  logic             w_cpu_gnt;
  logic             w_dma_gnt;
  logic [DBITS-1:0] w_addr;
  logic             w_we;
  logic             w_oor;
  logic             w_addr_unused;
  logic [DBITS-1:0] w_rdata;
  logic             r_cpu_pend;
  logic             r_dma_pend;
  logic             r_rd_oor;
  logic [DBITS-1:0] r_cpu_dout;
  logic [DBITS-1:0] r_dma_dout;

`ifdef DMEM_ARB_STARVE_EN
  logic w_wait_clr;
  logic w_wait_inc;

  assign w_wait_clr = w_dma_gnt;
  assign w_wait_inc = dma_req & ~w_dma_gnt;

  arb_wait_ctr #(.MAXWAIT(MAXWAIT)) u_wait_ctr (
    .CLK        (CLK),
    .RST        (RST),
    .i_clr      (w_wait_clr),
    .i_inc      (w_wait_inc),
    .o_at_limit (w_force)
  );
`else
  assign w_force = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_NORM;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = S_NORM;
    if (w_dma_gnt && dma_lock) w_state_nxt = S_BURST;
  end

  // A burst that loses dma_req or dma_lock falls back to normal arbitration in the same cycle.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dma_gnt = 1'b0;
    if (!RST) begin
      if (r_state == S_BURST && dma_req && dma_lock) w_dma_gnt = 1'b1;
      else if (dma_req && (w_force || !cpu_req))    w_dma_gnt = 1'b1;
      else if (cpu_req)                              w_cpu_gnt = 1'b1;
    end
  end

  assign cpu_gnt = w_cpu_gnt;
  assign dma_gnt = w_dma_gnt;

  always_comb begin
    w_addr  = w_dma_gnt ? dma_addr : cpu_addr;
    mem_din = w_dma_gnt ? dma_din  : cpu_din;
    w_we    = w_dma_gnt ? dma_we   : (w_cpu_gnt & cpu_we);
  end

  assign w_oor         = |w_addr[DBITS-1:RANGE_BIT];
  assign w_addr_unused = w_addr[0];
  assign mem_addr      = w_addr[ABITS:1];
  assign mem_we        = (w_cpu_gnt | w_dma_gnt) & w_we & ~w_oor;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cpu_pend <= 1'b0;
      r_dma_pend <= 1'b0;
      r_rd_oor   <= 1'b0;
      r_cpu_dout <= '0;
      r_dma_dout <= '0;
    end else begin
      r_cpu_pend <= w_cpu_gnt & ~cpu_we;
      r_dma_pend <= w_dma_gnt & ~dma_we;
      r_rd_oor   <= w_oor;
      if (cpu_rvalid) r_cpu_dout <= w_rdata;
      if (dma_rvalid) r_dma_dout <= w_rdata;
    end
  end

  // Read data returns straight from memory in the cycle after grant; gating with RST
  // keeps a read issued just before reset from completing.
  assign w_rdata    = r_rd_oor ? DBITS'(DEAD) : mem_dout;
  assign cpu_rvalid = r_cpu_pend & ~RST;
  assign dma_rvalid = r_dma_pend & ~RST;
  assign cpu_dout   = cpu_rvalid ? w_rdata : r_cpu_dout;
  assign dma_dout   = dma_rvalid ? w_rdata : r_dma_dout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed literal cases plus random traffic against a reference model.
module tb_dmem_arbiter;

  localparam int MAXWAIT = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [15:0] cpu_addr, cpu_din, dma_addr, dma_din;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_we;
  logic [15:0] cpu_dout, dma_dout, mem_din, mem_dout;
  logic [11:0] mem_addr;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  dmem_arbiter #(.DBITS(16), .ABITS(12), .MAXWAIT(MAXWAIT)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_dout(cpu_dout),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
    .dma_addr(dma_addr), .dma_din(dma_din),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_dout(dma_dout),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  function automatic logic [15:0] init_val(logic [11:0] a);
    return 16'h5A5A ^ {4'h0, a};
  endfunction

  // Memory attached to the DUT: synchronous, read-first, one-cycle latency.
  logic [15:0] mem [0:4095];
  bit   [4095:0] mem_seen;
  always @(posedge CLK) begin
    mem_dout <= mem_seen[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
    if (mem_we) begin
      mem[mem_addr]      <= mem_din;
      mem_seen[mem_addr] <= 1'b1;
    end
  end

  // Reference model state
  logic [15:0] ref_mem [0:4095];
  bit   [4095:0] ref_seen;
  bit          m_valid = 1'b0;
  bit          m_burst;
  int          m_wait;
  bit          m_cpu_pend, m_dma_pend;
  logic [15:0] m_pend_data, m_cpu_dout, m_dma_dout;
  logic [1:0]  last_g;

  function automatic bit in_range(logic [15:0] a);
    return a[15:13] == 3'b000;
  endfunction

  function automatic logic [15:0] ref_read(logic [11:0] w);
    return ref_seen[w] ? ref_mem[w] : init_val(w);
  endfunction

  function automatic bit starve_force();
`ifdef DMEM_ARB_STARVE_EN
    return m_wait >= MAXWAIT;
`else
    return 1'b0;
`endif
  endfunction

  // {dma, cpu} grant the rules require given model state and current inputs
  function automatic logic [1:0] exp_gnt();
    if (RST) return 2'b00;
    if (m_burst && dma_req && dma_lock) return 2'b10;
    if (dma_req && (!cpu_req || starve_force())) return 2'b10;
    if (cpu_req) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [1:0]  g;
    logic [15:0] a, d;
    logic        we;
    bit          rv;
    g  = exp_gnt();
    a  = g[1] ? dma_addr : cpu_addr;
    d  = g[1] ? dma_din  : cpu_din;
    we = g[1] ? dma_we   : cpu_we;
    chk("cpu_gnt", 32'(cpu_gnt), 32'(g[0]));
    chk("dma_gnt", 32'(dma_gnt), 32'(g[1]));
    chk("mem_we", 32'(mem_we), 32'((g != 2'b00) && we && in_range(a)));
    if (g != 2'b00) chk("mem_addr", 32'(mem_addr), 32'(a[12:1]));
    if (g != 2'b00 && we) chk("mem_din", 32'(mem_din), 32'(d));
    if (m_valid) begin
      rv = !RST && m_cpu_pend;
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(rv));
      chk("cpu_dout", 32'(cpu_dout), 32'(rv ? m_pend_data : m_cpu_dout));
      rv = !RST && m_dma_pend;
      chk("dma_rvalid", 32'(dma_rvalid), 32'(rv));
      chk("dma_dout", 32'(dma_dout), 32'(rv ? m_pend_data : m_dma_dout));
    end
  endtask

  task automatic model_update();
    logic [1:0]  g;
    logic [15:0] a, d;
    logic        we;
    g  = exp_gnt();
    a  = g[1] ? dma_addr : cpu_addr;
    d  = g[1] ? dma_din  : cpu_din;
    we = g[1] ? dma_we   : cpu_we;
    last_g = g;
    if (RST) begin
      m_valid = 1'b1; m_burst = 1'b0; m_wait = 0;
      m_cpu_pend = 1'b0; m_dma_pend = 1'b0;
      m_cpu_dout = 16'h0; m_dma_dout = 16'h0; m_pend_data = 16'h0;
    end else begin
      if (m_cpu_pend) m_cpu_dout = m_pend_data;
      if (m_dma_pend) m_dma_dout = m_pend_data;
      m_cpu_pend = g[0] && !cpu_we;
      m_dma_pend = g[1] && !dma_we;
      if (g != 2'b00 && !we) m_pend_data = in_range(a) ? ref_read(a[12:1]) : 16'hDEAD;
      if (g != 2'b00 && we && in_range(a)) begin
        ref_mem[a[12:1]]  = d;
        ref_seen[a[12:1]] = 1'b1;
      end
      m_burst = g[1] && dma_lock;
      if (g[1]) m_wait = 0;
      else if (dma_req && m_wait < MAXWAIT) m_wait++;
    end
  endtask

  task automatic tick_check();
    @(negedge CLK);
    compare_model();
  endtask

  task automatic tick_adv();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic cyc();
    tick_check();
    tick_adv();
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = 16'h0; cpu_din = 16'h0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = 16'h0; dma_din = 16'h0;
  endtask

  function automatic logic [15:0] rand_addr();
    int unsigned r;
    r = $urandom;
    if (r % 5 == 0) return 16'hE000 | 16'(r >> 8);
    return 16'((r >> 8) % 64);
  endfunction

  task automatic rand_stim();
    RST = ($urandom % 50 == 0);
    if (!cpu_req || last_g[0]) begin
      cpu_req  = ($urandom % 3 != 0);
      cpu_we   = $urandom % 2;
      cpu_addr = rand_addr();
      cpu_din  = 16'($urandom);
    end
    if (!dma_req || last_g[1]) begin
      dma_req  = ($urandom % 3 != 0);
      dma_we   = $urandom % 2;
      dma_lock = $urandom % 2;
      dma_addr = rand_addr();
      dma_din  = 16'($urandom);
    end
  endtask

  initial begin
    last_g = 2'b00;
    idle();
    // Reset with both requesting: no grants, no write
    RST = 1; cpu_req = 1; dma_req = 1; dma_we = 1;
    for (int i = 0; i < 2; i++) begin
      tick_check();
      chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      tick_adv();
    end
    RST = 0; idle();
    tick_check();
    chk("post_rst_rvalid", 32'({cpu_rvalid, dma_rvalid}), 32'd0);
    chk("post_rst_douts", {cpu_dout, dma_dout}, 32'd0);
    tick_adv();

    // CPU read of byte 0x0204 -> word 0x102
    cpu_req = 1; cpu_addr = 16'h0204;
    tick_check();
    chk("rd_gnt", 32'(cpu_gnt), 32'd1);
    chk("rd_mem_addr", 32'(mem_addr), 32'h102);
    tick_adv();
    idle();
    tick_check();
    chk("rd_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("rd_dout", 32'(cpu_dout), 32'h5B58);
    tick_adv();

    // Out-of-range write suppressed, out-of-range read returns DEAD
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'hFFF8; cpu_din = 16'h1234;
    tick_check();
    chk("oor_wr_gnt", 32'(cpu_gnt), 32'd1);
    chk("oor_wr_we", 32'(mem_we), 32'd0);
    tick_adv();
    cpu_we = 0; cpu_addr = 16'hFFF0;
    cyc();
    idle();
    tick_check();
    chk("oor_rd_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("oor_rd_dout", 32'(cpu_dout), 32'hDEAD);
    tick_adv();

    // Locked DMA burst of three writes, CPU waiting from the second beat
    dma_req = 1; dma_lock = 1; dma_we = 1; dma_addr = 16'h0010; dma_din = 16'hA000;
    for (int i = 0; i < 3; i++) begin
      tick_check();
      chk("burst_dma_gnt", 32'(dma_gnt), 32'd1);
      chk("burst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      chk("burst_mem_we", 32'(mem_we), 32'd1);
      tick_adv();
      cpu_req = 1; cpu_addr = 16'h0012;
      dma_addr = 16'h0012 + 16'(2 * i); dma_din = 16'hA001 + 16'(i);
    end
    dma_req = 0; dma_lock = 0;
    tick_check();
    chk("burst_end_cpu_gnt", 32'(cpu_gnt), 32'd1);
    tick_adv();
    idle();
    tick_check();
    chk("burst_readback", 32'(cpu_dout), 32'hA001);
    tick_adv();

    // Reset while a locked DMA read is outstanding
    dma_req = 1; dma_lock = 1; dma_addr = 16'h0030;
    cyc();
    RST = 1;
    tick_check();
    chk("rst_burst_rvalid", 32'(dma_rvalid), 32'd0);
    chk("rst_burst_gnt", 32'(dma_gnt), 32'd0);
    tick_adv();
    RST = 0; cpu_req = 1; cpu_addr = 16'h0040;
    tick_check();
    chk("rst_norm_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("rst_norm_rvalid", 32'({cpu_rvalid, dma_rvalid}), 32'd0);
    chk("rst_norm_douts", {cpu_dout, dma_dout}, 32'd0);
    tick_adv();
    idle();
    RST = 1; cyc(); RST = 0;

    // Both requesting continuously from a cleared wait count
    cpu_req = 1; cpu_addr = 16'h0002; dma_req = 1; dma_addr = 16'h0004;
`ifdef DMEM_ARB_STARVE_EN
    for (int i = 0; i < 6; i++) begin
      tick_check();
      chk("starve_cpu_gnt", 32'(cpu_gnt), 32'(i != 4));
      chk("starve_dma_gnt", 32'(dma_gnt), 32'(i == 4));
      tick_adv();
    end
`else
    for (int i = 0; i < 20; i++) begin
      tick_check();
      chk("nostarve_dma_gnt", 32'(dma_gnt), 32'd0);
      tick_adv();
    end
`endif
    idle();
    cyc();

    for (int i = 0; i < 3000; i++) begin
      rand_stim();
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
